// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces a
// detected key with an external debounce counter and reports each accepted
// press once as a one-cycle key_valid strobe carrying a hex key_code.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   row[3:0]     keypad rows, active-low, asynchronous to clk
//   count_done   debounce window elapsed (level from debounce counter)
//   col[3:0]     keypad columns, one-hot active-low (registered)
//   reset_count  one-cycle pulse restarting the debounce counter (registered)
//   key_code     hex code of the last accepted key (registered, held)
//   key_valid    one-cycle strobe, new key_code accepted (registered)
//   key_held     high from acceptance until debounced release (registered)
module keypad_scanner #(
  parameter logic [15:0] SCAN_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       count_done,
  output logic [3:0] col,
  output logic       reset_count,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    S_SCAN       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_PRESSED    = 2'd2,
    S_DB_RELEASE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [15:0] dwell_q, dwell_d;
  logic        b_q, b_d;             // last seen level of the tracked row
  logic [1:0]  holdoff_q, holdoff_d; // cycles left during which count_done is stale
  logic [3:0]  col_q, col_d;
  logic        rc_q, rc_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic [3:0]  row_meta_q, row_sync_q;

  logic        b_s;
  logic        qual_s;

  // Hex value printed on the key at (row, column).
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    case ({r, c})
      4'd0:    v = 4'h1;
      4'd1:    v = 4'h2;
      4'd2:    v = 4'h3;
      4'd3:    v = 4'hA;
      4'd4:    v = 4'h4;
      4'd5:    v = 4'h5;
      4'd6:    v = 4'h6;
      4'd7:    v = 4'hB;
      4'd8:    v = 4'h7;
      4'd9:    v = 4'h8;
      4'd10:   v = 4'h9;
      4'd11:   v = 4'hC;
      4'd12:   v = 4'hE;
      4'd13:   v = 4'h0;
      4'd14:   v = 4'hF;
      4'd15:   v = 4'hD;
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  // Lowest-index row that is pulled low.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    if (!r[0]) begin
      idx = 2'd0;
    end else if (!r[1]) begin
      idx = 2'd1;
    end else if (!r[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  assign b_s    = row_sync_q[row_idx_q];
  // count_done is only trusted once the counter has had time to clear it.
  assign qual_s = (holdoff_q == 2'd0) && count_done;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      dwell_q   <= 16'd0;
      b_q       <= 1'b1;
      holdoff_q <= 2'd0;
      col_q     <= 4'b1110;
      rc_q      <= 1'b0;
      code_q    <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      dwell_q   <= dwell_d;
      b_q       <= b_d;
      holdoff_q <= holdoff_d;
      col_q     <= col_d;
      rc_q      <= rc_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    dwell_d   = dwell_q;
    b_d       = b_s;
    holdoff_d = (holdoff_q != 2'd0) ? (holdoff_q - 2'd1) : 2'd0;
    rc_d      = 1'b0;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;

    case (state_q)
      S_SCAN: begin
        b_d = 1'b1;
        if (dwell_q == (SCAN_CYCLES - 16'd1)) begin
          dwell_d = 16'd0;
          if (row_sync_q == 4'b1111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            // The latched row reads low at this point; track from there.
            row_idx_d = lowest_low(row_sync_q);
            b_d       = 1'b0;
            rc_d      = 1'b1;
            holdoff_d = 2'd3;
            state_d   = S_DB_PRESS;
          end
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      S_DB_PRESS: begin
        // An edge on the tracked row beats a simultaneous count_done.
        if (b_s != b_q) begin
          rc_d      = 1'b1;
          holdoff_d = 2'd3;
        end else if (qual_s) begin
          if (!b_s) begin
            state_d = S_PRESSED;
            code_d  = key_map(row_idx_q, col_idx_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            state_d   = S_SCAN;
            col_idx_d = col_idx_q + 2'd1;
            dwell_d   = 16'd0;
          end
        end else begin
          state_d = S_DB_PRESS;
        end
      end
      S_PRESSED: begin
        if (b_s) begin
          rc_d      = 1'b1;
          holdoff_d = 2'd3;
          state_d   = S_DB_RELEASE;
        end else begin
          state_d = S_PRESSED;
        end
      end
      S_DB_RELEASE: begin
        if (b_s != b_q) begin
          rc_d      = 1'b1;
          holdoff_d = 2'd3;
        end else if (qual_s) begin
          if (b_s) begin
            state_d   = S_SCAN;
            held_d    = 1'b0;
            col_idx_d = col_idx_q + 2'd1;
            dwell_d   = 16'd0;
          end else begin
            state_d = S_PRESSED;
          end
        end else begin
          state_d = S_DB_RELEASE;
        end
      end
      default: begin
        state_d   = S_SCAN;
        col_idx_d = 2'd0;
        dwell_d   = 16'd0;
      end
    endcase

    col_d = ~(4'b0001 << col_idx_d);
  end

  assign col         = col_q;
  assign reset_count = rc_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;

endmodule
